mmio_bus_arbiter: RTL and testbench

//  Shares the single mmio port (RAM + KBD/SWT/RTC/SEG/LED) between the IFU (read-only)
//  and the LSU (read/write). Grants one request at a time via round-robin, then drives
//  the mmio port for exactly one issue cycle and returns registered read data to the

---
 rtl/mmio_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 16 +
 rtl/mmio_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mmio_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_arb_pkg.sv
// Shared encodings for the mmio bus arbiter: FSM states, transaction owner and
// the fixed access type used for instruction fetches.
package mmio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   localparam int WDT_W_DEF = 4;

   // Fetches are always a 32-bit word, zero-extended into the data path.
   localparam int IF_WDT_OP = 6;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the side that
// did not own the previous grant wins. Purely combinational.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic [1:0] gnt
);

   // req[0]/gnt[0] is the IFU, req[1]/gnt[1] the LSU; last_owner=1 means LSU.
   always_comb begin
      gnt    = 2'b00;
      gnt[0] = req[0] & (~req[1] | last_owner);
      gnt[1] = req[1] & (~req[0] | ~last_owner);
   end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter sharing the single mmio port between the IFU and the LSU.
// Optional grant/conflict counters are enabled by defining MMIO_ARB_PERF_EN.
module mmio_bus_arbiter
   import mmio_arb_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int WDT_W  = WDT_W_DEF,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic [WDT_W-1:0]  ls_wdt_op,
   output logic              ls_gnt,
   output logic              ls_rsp_valid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [WDT_W-1:0]  wdt_op,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
`ifdef MMIO_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_if_cnt,
   output logic [PERF_W-1:0] perf_ls_cnt,
   output logic [PERF_W-1:0] perf_conflict_cnt
`endif
);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            last_owner_q, last_owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [WDT_W-1:0]  op_q, op_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              grant_en;
   logic [1:0]        gnt;

   // No grant while the port is busy issuing or while reset is held.
   assign grant_en = rst_n & (state_q != ISSUE);

   rr_arb2 u_rr_arb2 (
      .req        ({ls_req, if_req} & {2{grant_en}}),
      .last_owner (last_owner_q == OWN_LS),
      .gnt        (gnt)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      op_d         = op_q;
      rdata_d      = rdata_q;
      case (state_q)
         ISSUE: begin
            state_d = RESP;
            rdata_d = we_q ? '0 : mem_rdata;
         end
         default: begin
            state_d = IDLE;
            if (gnt[0]) begin
               state_d      = ISSUE;
               owner_d      = OWN_IF;
               last_owner_d = OWN_IF;
               addr_d       = if_addr;
               wdata_d      = '0;
               we_d         = 1'b0;
               op_d         = WDT_W'(IF_WDT_OP);
            end else if (gnt[1]) begin
               state_d      = ISSUE;
               owner_d      = OWN_LS;
               last_owner_d = OWN_LS;
               addr_d       = ls_addr;
               wdata_d      = ls_wdata;
               we_d         = ls_we;
               op_d         = ls_wdt_op;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IF;
         last_owner_q <= OWN_LS;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         op_q         <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         op_q         <= op_d;
         rdata_q      <= rdata_d;
      end
   end

   // Strobes are qualified by rst_n so a reset mid-transaction never commits.
   always_comb begin
      if_gnt       = gnt[0];
      ls_gnt       = gnt[1];
      mem_raddr    = addr_q;
      mem_waddr    = addr_q;
      mem_wdata    = wdata_q;
      wdt_op       = op_q;
      mem_ren      = rst_n & (state_q == ISSUE) & ~we_q;
      mem_wen      = rst_n & (state_q == ISSUE) & we_q;
      if_rsp_valid = rst_n & (state_q == RESP) & (owner_q == OWN_IF);
      ls_rsp_valid = rst_n & (state_q == RESP) & (owner_q == OWN_LS);
      if_rdata     = (owner_q == OWN_IF) ? rdata_q : '0;
      ls_rdata     = (owner_q == OWN_LS) ? rdata_q : '0;
      busy         = (state_q != IDLE);
   end

`ifdef MMIO_ARB_PERF_EN
   logic [PERF_W-1:0] perf_if_q, perf_if_d;
   logic [PERF_W-1:0] perf_ls_q, perf_ls_d;
   logic [PERF_W-1:0] perf_cf_q, perf_cf_d;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      perf_if_d = gnt[0] ? sat_inc(perf_if_q) : perf_if_q;
      perf_ls_d = gnt[1] ? sat_inc(perf_ls_q) : perf_ls_q;
      perf_cf_d = (grant_en & if_req & ls_req) ? sat_inc(perf_cf_q) : perf_cf_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_if_q <= '0;
         perf_ls_q <= '0;
         perf_cf_q <= '0;
      end else begin
         perf_if_q <= perf_if_d;
         perf_ls_q <= perf_ls_d;
         perf_cf_q <= perf_cf_d;
      end
   end

   assign perf_if_cnt       = perf_if_q;
   assign perf_ls_cnt       = perf_ls_q;
   assign perf_conflict_cnt = perf_cf_q;
`endif

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter with a small mmio model and a response
// scoreboard; grant-time expectations are queued and matched on rsp_valid.
module tb_mmio_bus_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int WW = 4;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_rsp_valid;
   logic [DW-1:0] if_rdata;
   logic          ls_req, ls_we;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata;
   logic [WW-1:0] ls_wdt_op;
   logic          ls_gnt, ls_rsp_valid;
   logic [DW-1:0] ls_rdata;
   logic [AW-1:0] mem_raddr, mem_waddr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ren, mem_wen;
   logic [WW-1:0] wdt_op;
   logic          busy;
`ifdef MMIO_ARB_PERF_EN
   logic [PW-1:0] perf_if_cnt, perf_ls_cnt, perf_conflict_cnt;
`endif

   mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WDT_W(WW), .PERF_W(PW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_gnt       (if_gnt),
      .if_rsp_valid (if_rsp_valid),
      .if_rdata     (if_rdata),
      .ls_req       (ls_req),
      .ls_we        (ls_we),
      .ls_addr      (ls_addr),
      .ls_wdata     (ls_wdata),
      .ls_wdt_op    (ls_wdt_op),
      .ls_gnt       (ls_gnt),
      .ls_rsp_valid (ls_rsp_valid),
      .ls_rdata     (ls_rdata),
      .mem_raddr    (mem_raddr),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .mem_ren      (mem_ren),
      .mem_wen      (mem_wen),
      .wdt_op       (wdt_op),
      .mem_rdata    (mem_rdata),
      .busy         (busy)
`ifdef MMIO_ARB_PERF_EN
      ,
      .perf_if_cnt       (perf_if_cnt),
      .perf_ls_cnt       (perf_ls_cnt),
      .perf_conflict_cnt (perf_conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [AW-1:0] SEG_ADDR = 64'h0000_0000_A000_0010;

   // RAM content is a fixed function of address; 0x8000_0000 holds 0xDEAD_BEEF.
   function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
      if (a == 64'h8000_0000) return 64'h0000_0000_DEAD_BEEF;
      return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
   endfunction

   assign mem_rdata = ram_f(mem_raddr);

   logic [DW-1:0] seg_q = '0;
   int            wen_cycles = 0;
   always @(negedge clk) begin
      if (mem_wen) begin
         if (mem_waddr == SEG_ADDR) seg_q <= mem_wdata;
         wen_cycles <= wen_cycles + 1;
      end
   end

   typedef struct packed {
      logic          owner;   // 0 = IFU, 1 = LSU
      logic [DW-1:0] data;
   } sb_t;

   sb_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  rsp_cnt = 0;
   logic s_if_gnt, s_ls_gnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, match responses, queue new grants, then
   // return 1 time unit after the following posedge for the next drive.
   task automatic cyc();
      sb_t e;
      @(negedge clk);
      s_if_gnt = if_gnt;
      s_ls_gnt = ls_gnt;
      chk("gnt_exclusive", {63'd0, if_gnt & ls_gnt}, 64'd0);
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (if_rsp_valid || ls_rsp_valid) begin
            chk("rsp_exclusive", {63'd0, if_rsp_valid & ls_rsp_valid}, 64'd0);
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_owner", {63'd0, ls_rsp_valid}, {63'd0, e.owner});
               chk("rsp_data", e.owner ? ls_rdata : if_rdata, e.data);
               rsp_cnt++;
            end
         end
         if (if_gnt) sb.push_back('{owner: 1'b0, data: ram_f(if_addr)});
         if (ls_gnt) sb.push_back('{owner: 1'b1, data: ls_we ? '0 : ram_f(ls_addr)});
      end
      @(posedge clk);
      #1;
   endtask

   logic [1:0] exp_gnt3 [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
   int         base;

   initial begin
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wdt_op = '0;
      @(posedge clk); #1;
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ctrl", {58'd0, if_gnt, ls_gnt, if_rsp_valid, ls_rsp_valid, mem_ren, mem_wen}, 64'd0);
      chk("rst_raddr", mem_raddr, 64'd0);
      chk("rst_if_rdata", if_rdata, 64'd0);
      @(posedge clk); #1;

      // 1: IFU alone reads 0x8000_0000
      if_req = 1'b1; if_addr = 64'h8000_0000;
      base = rsp_cnt;
      cyc();
      chk("t1_gnt", {62'd0, s_ls_gnt, s_if_gnt}, 64'b01);
      if_req = 1'b0;
      @(negedge clk);
      chk("t1_issue", {61'd0, busy, mem_ren, mem_wen}, 64'b110);
      chk("t1_raddr", mem_raddr, 64'h8000_0000);
      chk("t1_wdt", {60'd0, wdt_op}, 64'd6);
      @(posedge clk); #1;
      cyc();
      chk("t1_rsp_cnt", rsp_cnt - base, 64'd1);
      cyc();
      chk("t1_idle", {63'd0, busy}, 64'd0);

      // 2: LSU write 0x1234 to the SEG register
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = SEG_ADDR; ls_wdata = 64'h1234; ls_wdt_op = 4'd3;
      base = rsp_cnt;
      cyc();
      chk("t2_gnt", {62'd0, s_ls_gnt, s_if_gnt}, 64'b10);
      ls_req = 1'b0; ls_we = 1'b0;
      @(negedge clk);
      chk("t2_issue", {62'd0, mem_ren, mem_wen}, 64'b01);
      chk("t2_waddr", mem_waddr, SEG_ADDR);
      chk("t2_wdata", mem_wdata, 64'h1234);
      @(posedge clk); #1;
      cyc();
      chk("t2_wen_once", wen_cycles, 64'd1);
      chk("t2_seg", seg_q, 64'h1234);
      chk("t2_rsp_cnt", rsp_cnt - base, 64'd1);
      cyc();

      // 3: both request continuously straight after reset
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      if_req = 1'b1; if_addr = 64'h8000_0000;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_0100; ls_wdt_op = 4'd3;
      base = rsp_cnt;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk($sformatf("t3_gnt%0d", i), {62'd0, s_ls_gnt, s_if_gnt}, {62'd0, exp_gnt3[i]});
      end
      if_req = 1'b0; ls_req = 1'b0;
      cyc();
      chk("t3_rsp_cnt", rsp_cnt - base, 64'd4);
`ifdef MMIO_ARB_PERF_EN
      chk("t3_perf_if", perf_if_cnt, 64'd2);
      chk("t3_perf_ls", perf_ls_cnt, 64'd2);
      chk("t3_perf_conflict", perf_conflict_cnt, 64'd4);
`endif

      // 4: back-to-back LSU reads
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_0000;
      base = rsp_cnt;
      cyc();
      chk("t4_gnt_a", {63'd0, s_ls_gnt}, 64'd1);
      ls_addr = 64'h8000_0008;
      cyc();
      chk("t4_issue_nognt", {63'd0, s_ls_gnt}, 64'd0);
      cyc();
      chk("t4_gnt_b", {63'd0, s_ls_gnt}, 64'd1);
      chk("t4_rsp_a", rsp_cnt - base, 64'd1);
      ls_req = 1'b0;
      cyc();
      cyc();
      chk("t4_rsp_b", rsp_cnt - base, 64'd2);

      // 5: reset during ISSUE of an LSU write drops the transaction
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = SEG_ADDR; ls_wdata = 64'h5555;
      base = rsp_cnt;
      cyc();
      chk("t5_gnt", {63'd0, s_ls_gnt}, 64'd1);
      ls_req = 1'b0; ls_we = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_wen_in_reset", {63'd0, mem_wen}, 64'd0);
      @(posedge clk); #1;
      sb.delete();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_after", {61'd0, busy, ls_rsp_valid, mem_wen}, 64'd0);
      @(posedge clk); #1;
      cyc();
      cyc();
      chk("t5_no_rsp", rsp_cnt - base, 64'd0);
      chk("t5_seg_kept", seg_q, 64'h1234);
      chk("sb_drained", sb.size(), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
